reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Consumes the synchronized, active-high reset produced by the per-domain reset synchronizer. Releases NUM_STAGES downstream reset outputs in a fixed order: an initial hold time, then a programmable gap between successive stages. Also provides a soft-reset request/acknowledge so local logic can re-run the sequence without a global reset. All outputs are registered and glitch-free.

Parameters:
NUM_STAGES, 3, number of ordered reset outputs (>=1)
HOLD_CYCLES, 16, cycles from reset release to deassertion of rst_o[0] (>=1)
GAP_CYCLES, 4, cycles between deassertion of rst_o[k-1] and rst_o[k] (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high; already synchronized to clk_i
swRstReq_i  input  1  soft-reset request, level, synchronous to clk_i
swRstAck_o  output  1  one-cycle pulse: soft-reset request accepted
rst_o  output  NUM_STAGES  staged resets, active-high; bit 0 released first
ready_o  output  1  high once all stages are released

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
- rst_i high, sampled at an edge: after that edge, rst_o = all ones, ready_o = 0, swRstAck_o = 0, state HOLD, counter = 0. rst_i has priority over everything else.
- States: HOLD -> STAGE(k), for k = 1..NUM_STAGES-1 -> DONE.
- HOLD:
  - Counter increments on each edge where rst_i and swRstReq_i are both sampled low.
  - Edge 0 is the first such edge. At edge HOLD_CYCLES (counter reaches HOLD_CYCLES), rst_o[0] is cleared, the counter clears, and the FSM moves to STAGE(1). If NUM_STAGES = 1, it moves to DONE instead.
- STAGE(k):
  - Counter counts GAP_CYCLES edges.
  - On the final edge, rst_o[k] is cleared and the counter clears.
  - The FSM then moves to STAGE(k+1), or to DONE after the last stage.
- DONE: ready_o is set on the edge after the one that clears rst_o[NUM_STAGES-1]. It holds until rst_i or a soft reset.
- Timing with rst_i first sampled low at edge 0:
  - rst_o[k] is low after edge HOLD_CYCLES + k*GAP_CYCLES.
  - ready_o is high after edge HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES + 1.
- Cleared rst_o bits never re-assert except through rst_i or a soft reset. rst_o[k] = 0 implies rst_o[j] = 0 for all j < k.
- Soft reset, accepted in any state while rst_i is low:
  - Each edge with swRstReq_i sampled high behaves like rst_i: rst_o all ones, ready_o 0, counter 0, state HOLD.
  - swRstAck_o pulses high for exactly one cycle, after the first edge where swRstReq_i is sampled high following a low sample (rising-edge detect, registered).
  - A request held high gives one ack, not repeated acks.
  - Timing restarts from the first edge with swRstReq_i sampled low.
  - The edge-detect history register is cleared by rst_i. A request already high when rst_i releases produces an ack on the first edge after release.
- Simultaneous rst_i and swRstReq_i: reset behaviour applies, no ack.
- Reset or soft reset mid-sequence: all stages re-assert on the next edge, and the full sequence restarts from HOLD.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). It has no wrap-around because it is always cleared on a state change.
- Elaboration error if any parameter is < 1.

Test Plan:
- Defaults; rst_i high 5 cycles, then low (edge 0) -> rst_o=111 until edge 15; 110 after edge 16; 100 after edge 20; 000 after edge 24; ready_o 1 after edge 25; swRstAck_o stays 0.
- Defaults; rst_i reasserted at edge 18 (rst_o=110) -> after edge 18 rst_o=111, ready_o 0. Release again -> identical 16/20/24/25 timing from the new edge 0.
- Defaults; in DONE, swRstReq_i high for 1 cycle -> swRstAck_o high exactly 1 cycle, rst_o=111, ready_o 0. Release timing 16/20/24/25 counted from the first low sample.
- Defaults; swRstReq_i held high 10 cycles during STAGE(1) -> exactly one ack pulse, rst_o=111 for the whole request, then a full resequence.
- Defaults; rst_i and swRstReq_i rise on the same edge -> rst_o=111, no ack. rst_i falls while the request is still high -> one ack on the next edge.
- NUM_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1; rst_i low at edge 0 -> rst_o=0 after edge 1, ready_o 1 after edge 2.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release: holds every downstream reset for a fixed time after the synchronized
// reset drops, then frees them one by one. A level soft-reset request restarts the sequence.
module reset_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  swRstReq_i,
   output logic                  swRstAck_o,
   output logic [NUM_STAGES-1:0] rst_o,
   output logic                  ready_o
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

   if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
      $error("reset_sequencer: NUM_STAGES, HOLD_CYCLES and GAP_CYCLES must all be >= 1");
   end

   typedef enum logic [1:0] {
      HOLD,
      STAGE,
      DONE
   } state_t;

   state_t                  state;
   logic [CW-1:0]           count;
   logic                    req_prev;
   logic [NUM_STAGES-1:0]   next_rst;

   // Stages release in bit order, so shifting left clears exactly the next stage.
   assign next_rst = rst_o << 1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= HOLD;
         count      <= '0;
         rst_o      <= '1;
         ready_o    <= 1'b0;
         swRstAck_o <= 1'b0;
         req_prev   <= 1'b0;
      end else begin
         req_prev   <= swRstReq_i;
         swRstAck_o <= swRstReq_i & ~req_prev;
         if (swRstReq_i) begin
            state   <= HOLD;
            count   <= '0;
            rst_o   <= '1;
            ready_o <= 1'b0;
         end else begin
            case (state)
               HOLD: begin
                  if (count == HOLD_LAST) begin
                     rst_o <= next_rst;
                     count <= '0;
                     state <= (next_rst == '0) ? DONE : STAGE;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               STAGE: begin
                  if (count == GAP_LAST) begin
                     rst_o <= next_rst;
                     count <= '0;
                     state <= (next_rst == '0) ? DONE : STAGE;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               DONE: begin
                  ready_o <= 1'b1;
               end
               default: begin
                  state <= HOLD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: a default instance and a minimal (1/1/1) instance share stimulus and are
// compared every cycle against a model based on the count of consecutive quiet edges.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       sw_req;
   logic [2:0] rst_o_d;
   logic       ready_d;
   logic       ack_d;
   logic [0:0] rst_o_m;
   logic       ready_m;
   logic       ack_m;

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reset_sequencer dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .swRstReq_i (sw_req),
      .swRstAck_o (ack_d),
      .rst_o      (rst_o_d),
      .ready_o    (ready_d)
   );

   reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
      .clk_i      (clk),
      .rst_i      (rst),
      .swRstReq_i (sw_req),
      .swRstAck_o (ack_m),
      .rst_o      (rst_o_m),
      .ready_o    (ready_m)
   );

   // Model state: quiet = edges in a row with both rst and sw_req low since the last reset-like edge.
   int   quiet = 0;
   bit   model_valid = 0;
   bit   prev_req = 0;
   logic exp_ack = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         quiet       = 0;
         model_valid = 1;
         prev_req    = 0;
         exp_ack     = 1'b0;
      end else begin
         exp_ack  = sw_req && !prev_req;
         prev_req = sw_req;
         if (sw_req) quiet = 0;
         else if (quiet < 100000) quiet++;
      end
   end

   // Stage k is free once the last quiet edge index (quiet-1) has reached HOLD + k*GAP.
   function automatic logic [7:0] expRst(int ns, int h, int g, int n);
      logic [7:0] v;
      v = '0;
      for (int k = 0; k < ns; k++) v[k] = !(n >= h + k * g + 1);
      return v;
   endfunction

   function automatic logic [7:0] expReady(int ns, int h, int g, int n);
      return {7'b0, n >= h + (ns - 1) * g + 2};
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("model_rst_def",   {5'b0, rst_o_d}, expRst(3, 16, 4, quiet));
         checkOutput("model_ready_def", {7'b0, ready_d}, expReady(3, 16, 4, quiet));
         checkOutput("model_ack_def",   {7'b0, ack_d},   {7'b0, exp_ack});
         checkOutput("model_rst_min",   {7'b0, rst_o_m}, expRst(1, 1, 1, quiet));
         checkOutput("model_ready_min", {7'b0, ready_m}, expReady(1, 1, 1, quiet));
         checkOutput("model_ack_min",   {7'b0, ack_m},   {7'b0, exp_ack});
      end
   end

   // Inputs change on the falling edge; the call returns one full cycle later.
   task automatic applyStimulus(input logic r, input logic q);
      rst    = r;
      sw_req = q;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acks;
      logic r;
      logic q;
      rst    = 1'b1;
      sw_req = 1'b0;
      @(negedge clk);

      // Power-on release with hand-computed edge numbers.
      repeat (5) applyStimulus(1'b1, 1'b0);
      checkOutput("lit_reset_rst", {5'b0, rst_o_d}, 8'h07);
      checkOutput("lit_reset_ready", {7'b0, ready_d}, 8'h00);
      for (int i = 1; i <= 26; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (i == 1)  checkOutput("lit_min_edge0", {7'b0, rst_o_m}, 8'h01);
         if (i == 2)  checkOutput("lit_min_edge1", {7'b0, rst_o_m}, 8'h00);
         if (i == 2)  checkOutput("lit_min_rdy1",  {7'b0, ready_m}, 8'h00);
         if (i == 3)  checkOutput("lit_min_rdy2",  {7'b0, ready_m}, 8'h01);
         if (i == 16) checkOutput("lit_edge15", {5'b0, rst_o_d}, 8'h07);
         if (i == 17) checkOutput("lit_edge16", {5'b0, rst_o_d}, 8'h06);
         if (i == 20) checkOutput("lit_edge19", {5'b0, rst_o_d}, 8'h06);
         if (i == 21) checkOutput("lit_edge20", {5'b0, rst_o_d}, 8'h04);
         if (i == 25) checkOutput("lit_edge24", {5'b0, rst_o_d}, 8'h00);
         if (i == 25) checkOutput("lit_rdy24",  {7'b0, ready_d}, 8'h00);
         if (i == 26) checkOutput("lit_rdy25",  {7'b0, ready_d}, 8'h01);
      end

      // Global reset in the middle of the sequence.
      repeat (18) applyStimulus(1'b1, 1'b0);
      repeat (18) applyStimulus(1'b0, 1'b0);
      checkOutput("lit_mid_before", {5'b0, rst_o_d}, 8'h06);
      applyStimulus(1'b1, 1'b0);
      checkOutput("lit_mid_rst", {5'b0, rst_o_d}, 8'h07);
      checkOutput("lit_mid_ready", {7'b0, ready_d}, 8'h00);
      repeat (30) applyStimulus(1'b0, 1'b0);

      // One-cycle soft reset from DONE.
      applyStimulus(1'b0, 1'b1);
      checkOutput("lit_sw_ack", {7'b0, ack_d}, 8'h01);
      checkOutput("lit_sw_rst", {5'b0, rst_o_d}, 8'h07);
      checkOutput("lit_sw_ready", {7'b0, ready_d}, 8'h00);
      applyStimulus(1'b0, 1'b0);
      checkOutput("lit_sw_ack_end", {7'b0, ack_d}, 8'h00);
      repeat (25) applyStimulus(1'b0, 1'b0);
      checkOutput("lit_sw_rdy", {7'b0, ready_d}, 8'h01);

      // Soft request held for ten cycles during STAGE(1) yields one ack.
      applyStimulus(1'b1, 1'b0);
      repeat (18) applyStimulus(1'b0, 1'b0);
      acks = 0;
      repeat (10) begin
         applyStimulus(1'b0, 1'b1);
         if (ack_d) acks++;
      end
      checkOutput("lit_held_acks", 8'(acks), 8'h01);
      repeat (27) applyStimulus(1'b0, 1'b0);

      // Reset and request rising together; request outlives the reset.
      repeat (3) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput("lit_both_noack", {7'b0, ack_d}, 8'h00);
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("lit_both_ack", {7'b0, ack_d}, 8'h01);
      applyStimulus(1'b0, 1'b1);
      checkOutput("lit_both_ack_end", {7'b0, ack_d}, 8'h00);
      repeat (27) applyStimulus(1'b0, 1'b0);

      // Randomized phase: rare resets, soft request toggling occasionally.
      q = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 14) == 0) q = ~q;
         applyStimulus(r, q);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
